loop_count_stack: RTL and testbench

- Parametrised successor to the ASIP loop count register.
- Holds an active loop count with load and decrement, plus a DEPTH-entry save/restore stack so the controller can run nested loops for the MAX/MIN/AVG routines.
- Flags zero, loop-done, stack full/empty and sticky overflow/underflow errors for the control unit.

---
 rtl/loop_count_stack.sv | 111 +++++++++++
 tb/tb_loop_count_stack.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/loop_count_stack.sv
// Loop count register with a save/restore stack for nested loops.
// One command executes per cycle, in priority order push > pop > load > dec.
// The module raises zero, loop-done, full/empty and sticky overflow/underflow flags.
module loop_count_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [WIDTH-1:0]           Count_in,
  input  logic                       Count_load,
  input  logic                       Count_dec,
  input  logic                       Count_push,
  input  logic                       Count_pop,
  input  logic                       Err_clr,
  output logic [WIDTH-1:0]           Count_out,
  output logic                       zero_flag,
  output logic                       loop_done,
  output logic [$clog2(DEPTH+1)-1:0] Depth_out,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             push_en;
  logic             full, empty;
  logic [AW-1:0]    wr_idx, rd_idx;

  logic [WIDTH-1:0] stack_q [DEPTH];

  assign full   = (depth_q == DW'(DEPTH));
  assign empty  = (depth_q == '0);
  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - DW'(1));

  // Next-state: only the highest-priority command acts. A new error overrides Err_clr.
  always_comb begin
    count_d = count_q;
    depth_d = depth_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q & ~Err_clr;
    udf_d   = udf_q & ~Err_clr;
    push_en = 1'b0;
    if (Count_push) begin
      if (!full) begin
        push_en = 1'b1;
        depth_d = depth_q + DW'(1);
        count_d = Count_in;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (Count_pop) begin
      if (!empty) begin
        count_d = stack_q[rd_idx];
        depth_d = depth_q - DW'(1);
      end else begin
        udf_d = 1'b1;
      end
    end else if (Count_load) begin
      count_d = Count_in;
    end else if (Count_dec) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end
      done_d = (count_q == WIDTH'(1));
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
      depth_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      depth_q <= depth_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Stack storage; contents are meaningless above the depth pointer, so there is no reset.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      stack_q[wr_idx] <= count_q;
    end
  end

  assign Count_out   = count_q;
  assign zero_flag   = (count_q == '0);
  assign loop_done   = done_q;
  assign Depth_out   = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

endmodule

// File: tb/tb_loop_count_stack.sv
// Directed bench for loop_count_stack. An expected state is queued with each stimulus
// step and compared against the DUT after the clock edge.
module tb_loop_count_stack;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [WIDTH-1:0] Count_in;
  logic             Count_load, Count_dec, Count_push, Count_pop, Err_clr;
  logic [WIDTH-1:0] Count_out;
  logic             zero_flag, loop_done, stack_full, stack_empty, ovf_err, udf_err;
  logic [2:0]       Depth_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] count;
    logic [2:0] depth;
    logic       done;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t sb_q[$];

  loop_count_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Count_in   (Count_in),
    .Count_load (Count_load),
    .Count_dec  (Count_dec),
    .Count_push (Count_push),
    .Count_pop  (Count_pop),
    .Err_clr    (Err_clr),
    .Count_out  (Count_out),
    .zero_flag  (zero_flag),
    .loop_done  (loop_done),
    .Depth_out  (Depth_out),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string tag, input string fld, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [7:0] count,
                              input logic [2:0] depth, input logic done,
                              input logic ovf, input logic udf);
    exp_t e;
    e.tag = tag; e.count = count; e.depth = depth; e.done = done; e.ovf = ovf; e.udf = udf;
    sb_q.push_back(e);
  endtask

  // Pop one expected state and compare every output against it.
  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb_q.pop_front();
    cmp(e.tag, "count", Count_out, e.count);
    cmp(e.tag, "zero", {7'b0, zero_flag}, {7'b0, e.count == 8'd0});
    cmp(e.tag, "done", {7'b0, loop_done}, {7'b0, e.done});
    cmp(e.tag, "depth", {5'b0, Depth_out}, {5'b0, e.depth});
    cmp(e.tag, "full", {7'b0, stack_full}, {7'b0, e.depth == 3'(DEPTH)});
    cmp(e.tag, "empty", {7'b0, stack_empty}, {7'b0, e.depth == 3'd0});
    cmp(e.tag, "ovf", {7'b0, ovf_err}, {7'b0, e.ovf});
    cmp(e.tag, "udf", {7'b0, udf_err}, {7'b0, e.udf});
  endtask

  task automatic drive(input logic push, input logic pop, input logic load, input logic dec,
                       input logic clr, input logic [7:0] din);
    Count_push = push; Count_pop = pop; Count_load = load; Count_dec = dec;
    Err_clr = clr; Count_in = din;
  endtask

  // One clocked step: drive, queue the expectation, clock, then compare.
  task automatic step(input string tag, input logic push, input logic pop, input logic load,
                      input logic dec, input logic clr, input logic [7:0] din,
                      input logic [7:0] count, input logic [2:0] depth, input logic done,
                      input logic ovf, input logic udf);
    drive(push, pop, load, dec, clr, din);
    expect_state(tag, count, depth, done, ovf, udf);
    @(posedge CLK);
    #1;
    check_out();
  endtask

  initial begin
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 8'd0);
    #1;
    expect_state("reset", 8'd0, 3'd0, 0, 0, 0);
    check_out();
    @(negedge CLK);
    RESET = 1'b1;

    //        tag        psh pop ld dec clr din     count  dep done ovf udf
    step("idle",       0,  0,  0, 0,  0,  8'd0,  8'd0,  3'd0, 0, 0, 0);
    step("load5",      0,  0,  1, 0,  0,  8'd5,  8'd5,  3'd0, 0, 0, 0);
    step("dec1",       0,  0,  0, 1,  0,  8'd0,  8'd4,  3'd0, 0, 0, 0);
    step("dec2",       0,  0,  0, 1,  0,  8'd0,  8'd3,  3'd0, 0, 0, 0);
    step("dec3",       0,  0,  0, 1,  0,  8'd0,  8'd2,  3'd0, 0, 0, 0);
    step("dec4",       0,  0,  0, 1,  0,  8'd0,  8'd1,  3'd0, 0, 0, 0);
    step("dec5",       0,  0,  0, 1,  0,  8'd0,  8'd0,  3'd0, 1, 0, 0);
    step("dec6sat",    0,  0,  0, 1,  0,  8'd0,  8'd0,  3'd0, 0, 0, 0);
    step("load3",      0,  0,  1, 0,  0,  8'd3,  8'd3,  3'd0, 0, 0, 0);
    step("push7",      1,  0,  0, 0,  0,  8'd7,  8'd7,  3'd1, 0, 0, 0);
    step("ndec1",      0,  0,  0, 1,  0,  8'd0,  8'd6,  3'd1, 0, 0, 0);
    step("ndec2",      0,  0,  0, 1,  0,  8'd0,  8'd5,  3'd1, 0, 0, 0);
    step("pop3",       0,  1,  0, 0,  0,  8'd0,  8'd3,  3'd0, 0, 0, 0);
    step("push1",      1,  0,  0, 0,  0,  8'd1,  8'd1,  3'd1, 0, 0, 0);
    step("push2",      1,  0,  0, 0,  0,  8'd2,  8'd2,  3'd2, 0, 0, 0);
    step("push3",      1,  0,  0, 0,  0,  8'd3,  8'd3,  3'd3, 0, 0, 0);
    step("push4",      1,  0,  0, 0,  0,  8'd4,  8'd4,  3'd4, 0, 0, 0);
    step("push5full",  1,  0,  1, 1,  0,  8'd5,  8'd4,  3'd4, 0, 1, 0);
    step("clrovf",     0,  0,  0, 0,  1,  8'd0,  8'd4,  3'd4, 0, 0, 0);
    step("popa",       0,  1,  0, 0,  0,  8'd0,  8'd3,  3'd3, 0, 0, 0);
    step("popb",       0,  1,  0, 0,  0,  8'd0,  8'd2,  3'd2, 0, 0, 0);
    step("popc",       0,  1,  0, 0,  0,  8'd0,  8'd1,  3'd1, 0, 0, 0);
    step("popd",       0,  1,  0, 0,  0,  8'd0,  8'd3,  3'd0, 0, 0, 0);
    step("load9",      0,  0,  1, 0,  0,  8'd9,  8'd9,  3'd0, 0, 0, 0);
    step("popempty",   0,  1,  1, 1,  0,  8'd1,  8'd9,  3'd0, 0, 0, 1);
    step("pushdec",    1,  0,  0, 1,  0,  8'd2,  8'd2,  3'd1, 0, 0, 1);
    step("pop9",       0,  1,  0, 0,  0,  8'd0,  8'd9,  3'd0, 0, 0, 1);
    step("popclr",     0,  1,  0, 0,  1,  8'd0,  8'd9,  3'd0, 0, 0, 1);
    step("clrudf",     0,  0,  0, 0,  1,  8'd0,  8'd9,  3'd0, 0, 0, 0);
    step("rpush5",     1,  0,  0, 0,  0,  8'd5,  8'd5,  3'd1, 0, 0, 0);
    step("rpush3",     1,  0,  0, 0,  0,  8'd3,  8'd3,  3'd2, 0, 0, 0);

    // Asynchronous reset between edges while a countdown is in progress.
    drive(0, 0, 0, 1, 0, 8'd0);
    #2;
    RESET = 1'b0;
    #1;
    expect_state("asyncrst", 8'd0, 3'd0, 0, 0, 0);
    check_out();
    @(posedge CLK);
    #1;
    expect_state("rsthold", 8'd0, 3'd0, 0, 0, 0);
    check_out();
    @(negedge CLK);
    RESET = 1'b1;
    step("postrst",    0,  0,  1, 0,  0,  8'd1,  8'd1,  3'd0, 0, 0, 0);
    step("postdec",    0,  0,  0, 1,  0,  8'd0,  8'd0,  3'd0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
